// File: rtl/fxp_sqrt.sv
// fxp_sqrt: sequential signed fixed-point square root, one root bit per cycle.
// out_C = floor(sqrt(in_A * 2^Q)); negative radicands are flagged through out_neg.
module fxp_sqrt #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [N-1:0] in_A,
  output logic         out_valid,
  output logic [N-1:0] out_C,
  output logic         out_neg,
  output logic         out_busy
);
  localparam int K = (N + Q) / 2;
  localparam int CW = $clog2(K + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [N+Q-1:0] rad;
  logic [K+2:0] rem, acc, trial, nxt_rem;
  logic [K-1:0] root, nxt_root;
  logic [CW-1:0] cnt;
  logic fit;
  // Bring down the next radicand digit pair and try appending a 1 to the root.
  always_comb begin
    acc = (rem << 2) | {{(K+1){1'b0}}, rad[N+Q-1 -: 2]};
    trial = {1'b0, root, 2'b01};
    fit = acc >= trial;
    nxt_rem = fit ? acc - trial : acc;
    nxt_root = (root << 1) | {{(K-1){1'b0}}, fit};
  end
  assign out_valid = state == DONE;
  assign out_busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rad <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      out_C <= '0;
      out_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (in_A[N-1]) begin
            out_neg <= 1'b1;
            out_C <= '0;
            state <= DONE;
          end else begin
            rad <= {in_A, {Q{1'b0}}};
            rem <= '0;
            root <= '0;
            cnt <= CW'(K);
            out_neg <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          rad <= rad << 2;
          rem <= nxt_rem;
          root <= nxt_root;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_C <= N'(nxt_root);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_sqrt.sv
// tb_fxp_sqrt: scoreboard bench for fxp_sqrt; expectations queued at issue, checked on out_valid.
module tb_fxp_sqrt;
  localparam int N = 32;
  localparam int Q = 16;
  localparam int K = (N + Q) / 2;
  typedef struct {
    logic [N-1:0] c;
    logic neg;
    int at;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic [N-1:0] in_A = '0;
  logic out_valid, out_neg, out_busy;
  logic [N-1:0] out_C;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  exp_t e;
  fxp_sqrt #(.N(N), .Q(Q)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_A(in_A),
    .out_valid(out_valid), .out_C(out_C), .out_neg(out_neg), .out_busy(out_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] ref_sqrt(input logic [N-1:0] a);
    longint unsigned v, lo, hi, mid;
    v = longint'(a) << Q;
    lo = 0;
    hi = 64'd1 << (K + 1);
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return N'(lo);
  endfunction
  task automatic push(input logic [N-1:0] c, input logic neg, input int at);
    exp_t x;
    x.c = c;
    x.neg = neg;
    x.at = at;
    sb.push_back(x);
  endtask
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] c, input logic neg);
    @(negedge clk);
    in_valid = 1'b1;
    in_A = a;
    push(c, neg, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_A = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * K) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 0);
  endtask
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (sb.size() == 0) check("spurious_valid", 64'(out_valid), 0);
      else begin
        e = sb.pop_front();
        check("out_C", out_C, e.c);
        check("out_neg", out_neg, e.neg);
        check("latency", 64'(cyc - e.at + 1), e.neg ? 1 : K + 1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] a;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(out_busy), 0);
    check("rst_C", out_C, 0);
    rstn = 1'b1;
    issue(32'h0004_0000, 32'h0002_0000, 1'b0);
    drain();
    issue(32'h0002_0000, 32'h0001_6A09, 1'b0);
    drain();
    issue(32'h0000_0001, 32'h0000_0100, 1'b0);
    drain();
    issue(32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0);
    drain();
    issue(32'h8000_0000, 32'h0, 1'b1);
    drain();
    issue(32'h0, 32'h0, 1'b0);
    drain();
    issue(32'hFFFF_0000, 32'h0, 1'b1);
    drain();
    issue(32'h0009_0000, 32'h0003_0000, 1'b0);
    repeat (2) @(negedge clk);
    check("neg_cleared", 64'(out_neg), 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      a = {1'b0, 31'($urandom)};
      issue(a, ref_sqrt(a), 1'b0);
      drain();
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_A = 32'h0019_0000;
    push(32'h0005_0000, 1'b0, cyc + 1);
    push(ref_sqrt(32'h0031_0000), 1'b0, cyc + 1 + K + 2);
    repeat (3) @(negedge clk);
    in_A = 32'h0031_0000;
    repeat (K) @(negedge clk);
    in_valid = 1'b0;
    drain();
    issue(32'h0004_0000, 32'h0002_0000, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_calc", 64'(out_busy), 1);
    rstn = 1'b0;
    sb.delete();
    #1;
    check("abort_valid", 64'(out_valid), 0);
    check("abort_busy", 64'(out_busy), 0);
    check("abort_C", out_C, 0);
    check("abort_neg", 64'(out_neg), 0);
    repeat (K + 4) @(negedge clk);
    rstn = 1'b1;
    in_valid = 1'b1;
    in_A = 32'h0002_0000;
    push(32'h0001_6A09, 1'b0, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(out_busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
